phase_decoder: RTL
==================

# phase_decoder

Receive-side counterpart of the multi-phase clock generator. Samples the `instr_clock` / `mem_clock` phase pair in the `clk` domain and checks it against the legal four-phase sequence. Emits one-cycle stage strobes (decode, load, exec, fetch) for the datapath, counts retired instructions and counts protocol violations. Sits between the clock generator and the core's stage-enable logic.

## Interface
- `CNT_W`, default 16: width of `instr_count`.
- `ERR_W`, default 8: width of `err_count`.

Ports:
- `clk`  in  1  system clock; same clock as the phase generator.
- `reset_n`  in  1  reset, synchronous and active-low.
- `instr_clock`  in  1  instruction phase from the generator; synchronous to `clk`.
- `mem_clock`  in  1  memory phase from the generator; synchronous to `clk`.
- `clr_err`  in  1  synchronous clear of `err` and `err_count`.
- `decode_stb`  out  1  one-cycle pulse on the 00→10 transition.
- `load_stb`  out  1  one-cycle pulse on the 10→11 transition.
- `exec_stb`  out  1  one-cycle pulse on the 11→10 transition.
- `fetch_stb`  out  1  one-cycle pulse on the 10→00 transition (instruction complete).
- `sync`  out  1  high while locked to the sequence.
- `err`  out  1  sticky protocol-violation flag.
- `instr_count`  out  CNT_W  completed instructions; wraps.
- `err_count`  out  ERR_W  violations; saturates at all-ones.

## Operation
- Pair notation: P = {instr_clock, mem_clock}. Legal cycle: 10, 11, 10, 00, repeating. Any number of consecutive 00 is legal; this is the generator's reset/idle value.
- Registers: `prev` (2 bits), `state`, all outputs. Every output is registered.
- States: HUNT, IDLE, DEC, LOAD, EXEC.
- HUNT:
  - P=00 → IDLE, `sync`=1.
  - Any other P → stay in HUNT.
  - No strobes and no errors are generated in HUNT.
- IDLE:
  - 00 → IDLE.
  - 10 → DEC, `decode_stb`.
  - Else error.
- DEC:
  - 11 → LOAD, `load_stb`.
  - Else error.
- LOAD:
  - 10 → EXEC, `exec_stb`.
  - Else error.
- EXEC:
  - 00 → IDLE, `fetch_stb`, `instr_count`+1 (mod 2^CNT_W).
  - Else error.
- P=01 is an error in every state except HUNT.
- Error:
  - Next state HUNT, `sync`=0, no strobe that cycle.
  - `err`=1.
  - `err_count`+1, saturating at 2^ERR_W−1.
- `clr_err`: `err`=0 and `err_count`=0 on the next edge.
  - If an error occurs on the same edge as `clr_err`, the error wins: `err`=1 and `err_count`=1.
- `clr_err` does not affect `state`, `sync` or `instr_count`.
- At most one strobe is high in any cycle.

## Timing
- P is sampled at posedge k. The resulting strobe, state and counter updates are visible from k to k+1.
- Latency: one `clk` from the input pair change to the strobe.
- For a free-running generator, strobes repeat every 4 cycles in the order decode, load, exec, fetch.
- `instr_count` increments in the same cycle that `fetch_stb` is high.
- Reset (`reset_n`=0 at a posedge):
  - `state`=HUNT, `prev`=00.
  - All strobes 0; `sync`=0; `err`=0; `instr_count`=0; `err_count`=0.
  - Reset overrides `clr_err` and all inputs.
- Reset mid-sequence: the block re-enters HUNT and resumes only after sampling 00. Remaining pairs of the interrupted instruction are ignored, with no error.
- Generator reset while locked: the pair is forced to 00.
  - From EXEC this is a legal fetch.
  - From DEC or LOAD it is an error (10→00 or 11→00 illegal outside EXEC).

## Configuration
- `PHASE_STALL_EN`
  - Defined: repeating the current non-00 pair is a legal stall. DEC holds on 10, LOAD on 11, EXEC on 10, with no strobe and no error, so a gated or slowed generator is supported.
  - Undefined: any repeat of a non-00 pair is an error. The generator must advance every cycle.
- Both builds: repeated 00 is always legal.

## Test plan
- Lock-on: reset for 3 cycles, then feed 00,10,11,10,00 ×3 → decode/load/exec/fetch pulse in order, one cycle after each change; `instr_count`=3; `err`=0; `sync`=1 from the first 00 after reset.
- Illegal 01: locked in LOAD, feed 01 → `err`=1, `err_count`=1, `sync`=0, no strobe. Then feed 10,00 → still HUNT until the 00 sample, then `sync`=1.
- Stall:
  - With `PHASE_STALL_EN`: 10,10,10 in DEC → `decode_stb` once, no error.
  - Without it: the second 10 → `err_count`=1.
- Saturation/wrap:
  - ERR_W=2: 5 errors → `err_count`=3.
  - CNT_W=4: 17 instructions → `instr_count`=1.
- Clear collision: `clr_err` on the same edge as an illegal 11→00 → `err`=1, `err_count`=1. `clr_err` alone next cycle → both 0.
- Reset mid-operation: assert `reset_n`=0 in EXEC, release while the input is 11 → no strobes or errors until 00 is sampled; `instr_count`=0.

Source files
------------

// File: rtl/phase_decoder.sv
// phase_decoder: checks the {instr_clock, mem_clock} pair against the legal
// four-phase sequence 10,11,10,00 and emits registered stage strobes,
// a wrapping instruction counter and a saturating violation counter.
// Optional build macro: PHASE_STALL_EN (a repeated non-00 pair is a legal stall).
module phase_decoder #(
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             instr_clock,
   input  logic             mem_clock,
   input  logic             clr_err,
   output logic             decode_stb,
   output logic             load_stb,
   output logic             exec_stb,
   output logic             fetch_stb,
   output logic             sync,
   output logic             err,
   output logic [CNT_W-1:0] instr_count,
   output logic [ERR_W-1:0] err_count
);

   // HUNT waits for a 00 sample before trusting the sequence; the other
   // states name the phase that the last accepted pair started.
   typedef enum logic [2:0] {
      ST_HUNT = 3'd0,
      ST_IDLE = 3'd1,
      ST_DEC  = 3'd2,
      ST_LOAD = 3'd3,
      ST_EXEC = 3'd4
   } state_t;

   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

`ifdef PHASE_STALL_EN
   localparam logic STALL_EN = 1'b1;
`else
   localparam logic STALL_EN = 1'b0;
`endif

   state_t           state_q, state_d;
   logic [1:0]       prev_q, prev_d;
   logic             decode_q, decode_d;
   logic             load_q, load_d;
   logic             exec_q, exec_d;
   logic             fetch_q, fetch_d;
   logic             sync_q, sync_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] icnt_q, icnt_d;
   logic [ERR_W-1:0] ecnt_q, ecnt_d;

   logic [1:0]       pair;
   logic             stall_ok;
   logic             viol;

   assign pair = {instr_clock, mem_clock};

   // A stall is the same non-idle pair seen on two consecutive samples.
   assign stall_ok = STALL_EN & (pair == prev_q) & (pair != 2'b00);

   // Next-state, strobe and counter computation for the sampled pair.
   always_comb begin
      state_d  = state_q;
      prev_d   = pair;
      decode_d = 1'b0;
      load_d   = 1'b0;
      exec_d   = 1'b0;
      fetch_d  = 1'b0;
      sync_d   = sync_q;
      err_d    = err_q;
      icnt_d   = icnt_q;
      ecnt_d   = ecnt_q;
      viol     = 1'b0;

      case (state_q)
         ST_HUNT: begin
            if (pair == 2'b00) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (pair == 2'b10) begin
               state_d  = ST_DEC;
               decode_d = 1'b1;
            end else if (pair != 2'b00) begin
               viol = 1'b1;
            end
         end
         ST_DEC: begin
            if (pair == 2'b11) begin
               state_d = ST_LOAD;
               load_d  = 1'b1;
            end else if (!stall_ok) begin
               viol = 1'b1;
            end
         end
         ST_LOAD: begin
            if (pair == 2'b10) begin
               state_d = ST_EXEC;
               exec_d  = 1'b1;
            end else if (!stall_ok) begin
               viol = 1'b1;
            end
         end
         ST_EXEC: begin
            if (pair == 2'b00) begin
               state_d = ST_IDLE;
               fetch_d = 1'b1;
               icnt_d  = icnt_q + CNT_W'(1);
            end else if (!stall_ok) begin
               viol = 1'b1;
            end
         end
         default: begin
            state_d = ST_HUNT;
         end
      endcase

      if (viol) state_d = ST_HUNT;
      sync_d = (state_d != ST_HUNT);

      // A violation on the clearing edge still records itself as the first.
      if (clr_err) begin
         err_d  = 1'b0;
         ecnt_d = '0;
      end
      if (viol) begin
         err_d = 1'b1;
         if (clr_err)               ecnt_d = ERR_W'(1);
         else if (ecnt_q != ERR_MAX) ecnt_d = ecnt_q + ERR_W'(1);
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_HUNT;
         prev_q   <= 2'b00;
         decode_q <= 1'b0;
         load_q   <= 1'b0;
         exec_q   <= 1'b0;
         fetch_q  <= 1'b0;
         sync_q   <= 1'b0;
         err_q    <= 1'b0;
         icnt_q   <= '0;
         ecnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         decode_q <= decode_d;
         load_q   <= load_d;
         exec_q   <= exec_d;
         fetch_q  <= fetch_d;
         sync_q   <= sync_d;
         err_q    <= err_d;
         icnt_q   <= icnt_d;
         ecnt_q   <= ecnt_d;
      end
   end

   assign decode_stb  = decode_q;
   assign load_stb    = load_q;
   assign exec_stb    = exec_q;
   assign fetch_stb   = fetch_q;
   assign sync        = sync_q;
   assign err         = err_q;
   assign instr_count = icnt_q;
   assign err_count   = ecnt_q;

endmodule
